// File: rtl/initial_try_2_pkg.sv
// Shared definitions for the 8N1 UART transmitter: FSM state encoding and
// the default baud divisor for a 12 MHz clock at 9600 baud.
package initial_try_2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 1250;
  localparam int COUNT_W              = 11;
  localparam int DATA_W               = 8;
  localparam int BIT_COUNT_W          = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider: count wraps every CLKS_PER_BIT clocks and
// tick is high combinationally in the last cycle of each bit period.
module uart_baud_gen
  import initial_try_2_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               nrst,
  output logic [COUNT_W-1:0] count,
  output logic               tick
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(CLKS_PER_BIT - 1);

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (nrst) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign count = count_q;
  assign tick  = (count_q == LAST);

endmodule

// File: rtl/initial_try_2.sv
// 8N1 UART transmitter that streams frames back to back: data_in is
// captured at every frame start and shifted out LSB first on tx.
module initial_try_2
  import initial_try_2_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   tx,
  output logic [COUNT_W-1:0]     count,
  output logic [BIT_COUNT_W-1:0] bit_count,
  output logic                   clk_pulse,
  output logic [1:0]             state
);

  state_t                   state_q, state_d;
  logic                     tx_q, tx_d;
  logic [BIT_COUNT_W-1:0]   bit_count_q, bit_count_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic [2:0]               next_idx;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .nrst  (nrst),
    .count (count),
    .tick  (clk_pulse)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      bit_count_q <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
    end
  end

  // Everything holds between ticks; each tick advances exactly one bit slot.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    next_idx    = bit_count_q[2:0] + 3'd1;
    if (clk_pulse) begin
      case (state_q)
        IDLE, STOP: begin
          state_d     = START;
          shift_d     = data_in;
          tx_d        = 1'b0;
          bit_count_d = '0;
        end
        START: begin
          state_d     = DATA;
          tx_d        = shift_q[0];
          bit_count_d = '0;
        end
        DATA: begin
          if (bit_count_q < BIT_COUNT_W'(7)) begin
            tx_d        = shift_q[next_idx];
            bit_count_d = bit_count_q + BIT_COUNT_W'(1);
          end else begin
            state_d     = STOP;
            tx_d        = 1'b1;
            bit_count_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          tx_d        = 1'b1;
          bit_count_d = '0;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign bit_count = bit_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_initial_try_2.sv
// Bench for initial_try_2: bytes are pushed to a queue when driven, and a
// mid-bit line decoder pops and compares every frame it recovers from tx.
module tb_initial_try_2;

  localparam int CPB        = 10;
  localparam int FRAME      = 10 * CPB;
  localparam int NUM_FRAMES = 100;

  logic        clk;
  logic        nrst;
  logic [7:0]  data_in;
  logic        tx;
  logic [10:0] count;
  logic [3:0]  bit_count;
  logic        clk_pulse;
  logic [1:0]  state;

  int checks;
  int errors;
  int cyc;
  int frames_done;
  bit mon_en;
  bit dec_abort;
  logic [7:0] exp_q[$];

  initial_try_2 #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .data_in   (data_in),
    .tx        (tx),
    .count     (count),
    .bit_count (bit_count),
    .clk_pulse (clk_pulse),
    .state     (state)
  );

  // clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    if (nrst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // baud divider reference: cycles since release modulo the bit period
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count), 32'(cyc % CPB));
      check("clk_pulse", 32'(clk_pulse), 32'((cyc % CPB) == CPB - 1));
    end
  end

  // line decoder: find each start edge, sample mid-bit, compare with queue
  initial begin : decoder
    logic       prev_tx;
    logic [7:0] got;
    int         idle;
    frames_done = 0;
    dec_abort   = 1'b0;
    wait (mon_en);
    prev_tx = 1'b1;
    idle    = 0;
    while (frames_done < NUM_FRAMES && !dec_abort) begin
      @(negedge clk);
      if (prev_tx && !tx) begin
        check("frame_start_time", 32'(cyc), 32'(CPB + FRAME * frames_done));
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        check("start_state", 32'(state), 32'd1);
        check("start_bit_count", 32'(bit_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx;
          check("data_state", 32'(state), 32'd2);
          check("data_bit_count", 32'(bit_count), 32'(i));
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", 32'(tx), 32'd1);
        check("stop_state", 32'(state), 32'd3);
        check("stop_bit_count", 32'(bit_count), 32'd0);
        if (exp_q.size() == 0) begin
          check("queue_not_empty", 32'd0, 32'd1);
        end else begin
          check("rx_byte", 32'(got), 32'(exp_q.pop_front()));
        end
        frames_done++;
        prev_tx = tx;
        idle    = 0;
      end else begin
        prev_tx = tx;
        idle++;
        if (idle > 2 * FRAME) begin
          check("start_edge_timeout", 32'd0, 32'd1);
          dec_abort = 1'b1;
        end
      end
    end
  end

  initial begin : main
    int         w;
    int         start_k;
    logic [7:0] byte_k;
    nrst    = 1'b1;
    data_in = 8'h00;
    mon_en  = 1'b0;
    checks  = 0;
    errors  = 0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_clk_pulse", 32'(clk_pulse), 32'd0);

    data_in = 8'h53;
    nrst    = 1'b0;
    mon_en  = 1'b1;

    // driver: present each byte half a bit before its latch edge, then
    // disturb data_in mid-frame with a value that must not be sent
    for (int k = 0; k < NUM_FRAMES; k++) begin
      start_k = CPB + k * FRAME;
      if (k == 0)      byte_k = 8'h53;
      else if (k == 1) byte_k = 8'h6E;
      else             byte_k = 8'($urandom_range(0, 255));
      wait_cyc(start_k - CPB / 2);
      data_in = byte_k;
      exp_q.push_back(byte_k);
      wait_cyc(start_k + 4 * CPB + 3);
      data_in = (k == 0) ? 8'h6E : 8'($urandom_range(0, 255));
    end

    w = 0;
    while (frames_done < NUM_FRAMES && !dec_abort && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    check("frames_decoded", 32'(frames_done), 32'(NUM_FRAMES));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // reset in the middle of a data bit
    w = 0;
    while (!(state == 2'd2 && bit_count == 4'd4) && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    check("reach_data_bit4", 32'(state == 2'd2 && bit_count == 4'd4), 32'd1);
    nrst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_bit_count", 32'(bit_count), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_clk_pulse", 32'(clk_pulse), 32'd0);

    nrst = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 3 * CPB) begin
      @(negedge clk);
      w++;
    end
    check("restart_latency", 32'(cyc), 32'(CPB));
    check("restart_state", 32'(state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/initial_try_2.md
INITIAL_TRY_2 -- requirements
Module: initial_try_2

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, meaning clocks per UART bit (12 MHz clock / 9600 baud).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock (12 MHz nominal), all logic on its rising edge.
REQ-003 SHALL have port nrst, input, 1, meaning the reset; reset is synchronous and active-high.
REQ-004 SHALL have port data_in, input, 8, meaning the byte to transmit, sampled at frame start.
REQ-005 SHALL have port tx, output, 1, meaning the serial line, idle high.
REQ-006 SHALL have port count, output, 11, meaning the baud divider counter value.
REQ-007 SHALL have port bit_count, output, 4, meaning the index of the data bit being sent.
REQ-008 SHALL have port clk_pulse, output, 1, meaning the one-clock bit-boundary tick.
REQ-009 SHALL have port state, output, 2, meaning the FSM state: IDLE=0, START=1, DATA=2, STOP=3.

Function
REQ-010 count SHALL increment by 1 every clock and wrap from CLKS_PER_BIT-1 to 0.
REQ-011 clk_pulse SHALL be combinational, 1 exactly when count == CLKS_PER_BIT-1, so it is high for one clock every CLKS_PER_BIT clocks.
REQ-012 State, tx, bit_count and the shift register SHALL change only on the edge that ends a clk_pulse-high cycle.
REQ-013 IDLE -> START on the first tick after reset; data_in latched into an 8-bit shift register; tx <= 0.
REQ-014 START -> DATA on the next tick; tx <= shift[0]; bit_count <= 0.
REQ-015 In DATA, each tick SHALL send the next bit LSB first (tx <= shift[bit_count+1], bit_count <= bit_count+1) while bit_count < 7.
REQ-016 DATA -> STOP on the tick with bit_count == 7; tx <= 1; bit_count <= 0.
REQ-017 STOP -> START on the next tick with no idle gap; data_in latched anew; tx <= 0.
REQ-018 A frame SHALL be exactly 10 bits (1 start, 8 data, 1 stop), i.e. 10*CLKS_PER_BIT clocks; back-to-back frames repeat with period 12500 clocks at default.
REQ-019 Changes on data_in between latch points SHALL NOT affect the frame in progress; the value present in the latch cycle is sent.
REQ-020 bit_count SHALL be 0 in IDLE, START and STOP.
REQ-021 tx SHALL be a registered output (glitch-free).

Reset
REQ-022 While nrst == 1 at a clock edge: count=0, state=IDLE, tx=1, bit_count=0, shift=0; clk_pulse thus 0.
REQ-023 Reset SHALL take priority over every transition, including mid-frame; after release, operation restarts per REQ-013 with the first tick CLKS_PER_BIT clocks later.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE/START/DATA/STOP, 2-bit) and the CLKS_PER_BIT default.
REQ-025 The baud counter/tick (count, clk_pulse) SHALL be a sub-module named uart_baud_gen; the FSM and shifter stay in initial_try_2.

Verification
REQ-026 Reset held 10 clocks -> tx=1, state=0, count=0, bit_count=0, clk_pulse=0.
REQ-027 Release reset with data_in=0x53 -> at clock 1250 state=1, tx=0; then tx bits 1,1,0,0,1,0,1,0 each 1250 clocks; stop tx=1 for 1250 clocks.
REQ-028 Change data_in 0x53->0x6E mid-DATA -> current frame still 0x53; next START follows STOP directly; next frame carries 0x6E.
REQ-029 Monitor count -> clk_pulse=1 only at count=1249, single cycle; count returns to 0 next clock.
REQ-030 Assert nrst during DATA (bit_count=4) -> next edge tx=1, state=0, bit_count=0, count=0.
REQ-031 100 random bytes, data_in updated once per 12500 clocks in sync with frames -> line decoder at mid-bit recovers every byte, stop bit always 1.
